// File: rtl/mem_pkt_rx_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : mem_pkt_rx_pkg                                             |
// | Description : Shared core types used by the memory-packet receive        |
// |               buffer: the AGEN result packet (memPkt), its execution     |
// |               flags (exeFlgs) and the load/store access size.            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package mem_pkt_rx_pkg;

  // Load/store access size.
  typedef enum logic [1:0] {
    BYTE        = 2'd0,
    HALF_WORD   = 2'd1,
    WORD        = 2'd2,
    DOUBLE_WORD = 2'd3
  } SIZE_DATA;

  // Execution flags carried with every packet.
  typedef struct packed {
    logic isLoad;
    logic isStore;
    logic destValid;
    logic signExt;
  } exeFlgs;

  // AGEN result packet handed to the LSQ address-update port.
  typedef struct packed {
    logic [7:0]  seqNo;
    logic [31:0] pc;
    exeFlgs      flags;
    SIZE_DATA    ldstSize;
    logic [5:0]  phyDest;
    logic [31:0] address;
    logic [31:0] src2Data;
    logic [4:0]  lsqID;
    logic [4:0]  alID;
    logic        valid;
  } memPkt;

endpackage
`default_nettype wire

// File: rtl/mem_pkt_fifo_ram.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mem_pkt_fifo_ram                                           |
// | Description : DEPTH x memPkt storage, one synchronous write port and     |
// |               one asynchronous read port. Contents are not reset.        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   clk      in   clock                                                    |
// |   we_i     in   write enable                                             |
// |   waddr_i  in   write address                                            |
// |   wdata_i  in   write data                                               |
// |   raddr_i  in   read address                                             |
// |   rdata_o  out  read data (combinational from raddr_i)                   |
// +--------------------------------------------------------------------------+
module mem_pkt_fifo_ram
  import mem_pkt_rx_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [PTR_W-1:0] waddr_i,
  input  memPkt            wdata_i,
  input  logic [PTR_W-1:0] raddr_i,
  output memPkt            rdata_o
);

  memPkt mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule
`default_nettype wire

// File: rtl/mem_pkt_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mem_pkt_rx                                                 |
// | Description : Receive buffer between the AGEN stage and the LSQ          |
// |               address-update port. Buffers up to DEPTH memPkt entries   |
// |               in order, presents the head entry to the LSQ, raises      |
// |               back-pressure one entry early, flushes on recovery and    |
// |               flags (sticky) any packet dropped while full.             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   clk            in   clock, rising edge                                 |
// |   reset          in   asynchronous active-high reset                     |
// |   recoverFlag_i  in   flush all buffered entries                         |
// |   memPacket_i    in   AGEN packet, .valid qualifies enqueue              |
// |   lsqReady_i     in   LSQ accepts the head entry this cycle              |
// |   lsqPacket_o    out  head entry (.valid mirrors lsqValid_o)             |
// |   lsqValid_o     out  buffer non-empty                                   |
// |   lsqIsLoad_o    out  head entry is a load                               |
// |   stall_o        out  back-pressure to the memory issue slot             |
// |   occupancy_o    out  current entry count                                |
// |   overflow_o     out  sticky: a packet was dropped while full            |
// +--------------------------------------------------------------------------+
module mem_pkt_rx
  import mem_pkt_rx_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             recoverFlag_i,
  input  memPkt            memPacket_i,
  input  logic             lsqReady_i,
  output memPkt            lsqPacket_o,
  output logic             lsqValid_o,
  output logic             lsqIsLoad_o,
  output logic             stall_o,
  output logic [PTR_W:0]   occupancy_o,
  output logic             overflow_o
);

  localparam logic [PTR_W:0] C_DEPTH  = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] C_ALMOST = (PTR_W+1)'(DEPTH - 1);

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W:0]   occ_q,  occ_d;
  logic             overflow_q, overflow_d;

  logic  w_full;
  logic  w_enq_req;
  logic  w_enq;
  logic  w_deq;
  logic  w_drop;
  memPkt w_head_pkt;

  // Storage. The write address is the tail and the read address the head;
  // when full with a simultaneous dequeue, head==tail and the read sees the
  // old entry this cycle while the new packet lands at the edge.
  mem_pkt_fifo_ram #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (w_enq),
    .waddr_i (tail_q),
    .wdata_i (memPacket_i),
    .raddr_i (head_q),
    .rdata_o (w_head_pkt)
  );

  assign lsqValid_o = (occ_q != '0);

  always_comb begin
    w_full    = (occ_q == C_DEPTH);
    w_deq     = lsqValid_o && lsqReady_i && !recoverFlag_i;
    w_enq_req = memPacket_i.valid && !recoverFlag_i;
    // A full buffer still accepts when the head leaves in the same cycle,
    // so occupancy holds at DEPTH instead of losing the packet.
    w_enq     = w_enq_req && (!w_full || w_deq);
    w_drop    = w_enq_req && w_full && !w_deq;
  end

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    occ_d      = occ_q;
    overflow_d = overflow_q | w_drop;
    if (recoverFlag_i) begin
      head_d = '0;
      tail_d = '0;
      occ_d  = '0;
    end else begin
      if (w_enq) tail_d = tail_q + PTR_W'(1);
      if (w_deq) head_d = head_q + PTR_W'(1);
      case ({w_enq, w_deq})
        2'b10:   occ_d = occ_q + (PTR_W+1)'(1);
        2'b01:   occ_d = occ_q - (PTR_W+1)'(1);
        default: occ_d = occ_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      occ_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      occ_q      <= occ_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is never reset, so the valid field is rebuilt from occupancy.
  always_comb begin
    lsqPacket_o       = w_head_pkt;
    lsqPacket_o.valid = lsqValid_o;
  end

  assign lsqIsLoad_o = lsqValid_o && w_head_pkt.flags.isLoad;
  // Asserted one entry early to absorb the packet already in AGEN.
  assign stall_o     = (occ_q >= C_ALMOST);
  assign occupancy_o = occ_q;
  assign overflow_o  = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_pkt_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_mem_pkt_rx                                              |
// | Description : Self-checking bench for mem_pkt_rx. Accepted packets are  |
// |               pushed to a scoreboard queue and popped/compared when the |
// |               LSQ takes the head entry.                                 |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_mem_pkt_rx;
  import mem_pkt_rx_pkg::*;

  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           recoverFlag_i = 1'b0;
  memPkt          memPacket_i = '0;
  logic           lsqReady_i = 1'b0;
  memPkt          lsqPacket_o;
  logic           lsqValid_o;
  logic           lsqIsLoad_o;
  logic           stall_o;
  logic [PTR_W:0] occupancy_o;
  logic           overflow_o;

  mem_pkt_rx #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .recoverFlag_i (recoverFlag_i),
    .memPacket_i   (memPacket_i),
    .lsqReady_i    (lsqReady_i),
    .lsqPacket_o   (lsqPacket_o),
    .lsqValid_o    (lsqValid_o),
    .lsqIsLoad_o   (lsqIsLoad_o),
    .stall_o       (stall_o),
    .occupancy_o   (occupancy_o),
    .overflow_o    (overflow_o)
  );

  always #5 clk = ~clk;

  int    n_cmp = 0;
  int    n_bad = 0;
  memPkt exp_q[$];
  int    m_occ = 0;
  bit    m_ovf = 1'b0;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input logic [PTR_W:0] obs, input logic [PTR_W:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chkp(input string tag, input memPkt obs, input memPkt exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed alID=%0d addr=%h pkt=%h expected alID=%0d addr=%h pkt=%h",
             tag, obs.alID, obs.address, obs, exp.alID, exp.address, exp);
    end
  endtask

  function automatic memPkt mk(input int id, input logic [31:0] addr, input bit ld);
    memPkt p;
    p.seqNo          = 8'(id + 100);
    p.pc             = addr + 32'h4000;
    p.flags.isLoad   = ld;
    p.flags.isStore  = !ld;
    p.flags.destValid = ld;
    p.flags.signExt  = id[0];
    p.ldstSize       = ld ? WORD : HALF_WORD;
    p.phyDest        = 6'(id + 7);
    p.address        = addr;
    p.src2Data       = ~addr;
    p.lsqID          = 5'(id + 3);
    p.alID           = 5'(id);
    p.valid          = 1'b1;
    return p;
  endfunction

  // Called at a falling edge: drives one cycle of stimulus, checks any
  // dequeue against the scoreboard, advances the reference model, then
  // checks the status outputs at the next falling edge.
  task automatic step(input bit v, input bit rdy, input bit rec, input memPkt p);
    memPkt exp;
    bit    m_deq;
    bit    m_acc;
    p.valid       = v;
    memPacket_i   = p;
    lsqReady_i    = rdy;
    recoverFlag_i = rec;
    m_deq = (m_occ != 0) && rdy && !rec;
    if (m_deq) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $error("FAIL sb_underflow: observed dequeue expected empty scoreboard");
      end else begin
        exp = exp_q.pop_front();
        chkp("sb_pkt", lsqPacket_o, exp);
        chk1("sb_isload", lsqIsLoad_o, exp.flags.isLoad);
      end
    end
    m_acc = v && !rec && ((m_occ < DEPTH) || m_deq);
    if (v && !rec && !m_acc) m_ovf = 1'b1;
    if (rec) begin
      m_occ = 0;
      exp_q.delete();
    end else begin
      if (m_acc) exp_q.push_back(p);
      m_occ = m_occ + int'(m_acc) - int'(m_deq);
    end
    @(negedge clk);
    chkn("occupancy", occupancy_o, (PTR_W+1)'(m_occ));
    chk1("lsq_valid", lsqValid_o, m_occ != 0);
    chk1("stall", stall_o, m_occ >= DEPTH - 1);
    chk1("overflow", overflow_o, m_ovf);
  endtask

  initial begin
    // Reset state.
    @(negedge clk);
    chkn("rst_occ", occupancy_o, '0);
    chk1("rst_valid", lsqValid_o, 1'b0);
    chk1("rst_stall", stall_o, 1'b0);
    chk1("rst_ovf", overflow_o, 1'b0);
    reset = 1'b0;
    @(negedge clk);

    // Single load through with the LSQ ready: one cycle latency.
    step(1, 1, 0, mk(5, 32'h1000, 1));
    chk1("a_isload", lsqIsLoad_o, 1'b1);
    chkp("a_pkt", lsqPacket_o, mk(5, 32'h1000, 1));
    step(0, 1, 0, '0);

    // Fill with LSQ stalled; 4th in-flight packet still accepted.
    for (int i = 0; i < 4; i++) step(1, 0, 0, mk(10 + i, 32'h2000 + 32'(i * 8), i[0]));
    // 5th packet dropped while full; overflow sticks.
    step(1, 0, 0, mk(14, 32'h2100, 1));
    for (int i = 0; i < 4; i++) step(0, 1, 0, '0);

    // Full with simultaneous enqueue/dequeue across pointer wrap, 10 packets.
    for (int i = 0; i < 4; i++) step(1, 0, 0, mk(20 + i, 32'h3000 + 32'(i * 4), 1));
    for (int i = 4; i < 10; i++) step(1, 1, 0, mk(20 + i, 32'h3000 + 32'(i * 4), i[1]));
    for (int i = 0; i < 4; i++) step(0, 1, 0, '0);

    // Recovery with a same-cycle packet: flushed and not stored.
    step(1, 0, 0, mk(1, 32'h4000, 1));
    step(1, 0, 0, mk(2, 32'h4004, 0));
    step(1, 1, 1, mk(3, 32'h4008, 1));
    step(1, 0, 0, mk(4, 32'h400C, 0));
    step(0, 1, 0, '0);

    // Asynchronous reset mid-stream with three entries buffered.
    for (int i = 0; i < 3; i++) step(1, 0, 0, mk(6 + i, 32'h5000 + 32'(i * 4), 1));
    #2;
    reset = 1'b1;
    #1;
    chkn("arst_occ", occupancy_o, '0);
    chk1("arst_valid", lsqValid_o, 1'b0);
    chk1("arst_stall", stall_o, 1'b0);
    chk1("arst_ovf", overflow_o, 1'b0);
    m_occ = 0;
    m_ovf = 1'b0;
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    step(1, 0, 0, mk(17, 32'h6000, 0));
    chk1("post_isload", lsqIsLoad_o, 1'b0);
    step(1, 1, 0, mk(18, 32'h6004, 1));
    step(0, 1, 0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
